// File: rtl/l2_sqrt.sv
// rtl/l2_sqrt.sv - FIFO-buffered restoring integer square root of a 20-bit sum of squares (optional rounding: L2_SQRT_ROUND_EN)
module l2_sqrt #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [19:0] i_f,
    input  logic        i_valid_in,
    input  logic        i_ovf_in,
    output logic [9:0]  o_r,
    output logic        o_valid_out,
    output logic        o_ovf_out,
    output logic        o_busy,
    output logic        o_drop
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Sample FIFO: each entry is {ovf, f}
    logic [20:0]   r_mem [0:FIFO_DEPTH-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Engine state
    state_t        r_state;
    logic [3:0]    r_iter;
    logic [19:0]   r_rad;
    logic [9:0]    r_root;
    logic [11:0]   r_rem;
    logic          r_ovf;

    // Registered outputs
    logic [9:0]    r_r;
    logic          r_valid;
    logic          r_ovf_out;
    logic          r_drop;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic [20:0]   w_head;
    logic [13:0]   w_rem_sh;
    logic [13:0]   w_trial;
    logic          w_ge;
    logic [11:0]   w_rem_next;
    logic [9:0]    w_root_next;
    logic [9:0]    w_result;

    // The pop decision uses the pre-edge count, so a word written into an
    // empty FIFO is never popped on the same edge, while a full FIFO that
    // is popped this edge still has room for the incoming write.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = (r_state == IDLE) && !w_empty;
    assign w_push  = i_valid_in && (!w_full || w_pop);
    assign w_head  = r_mem[r_rd_ptr];

    // One restoring step: bring down two radicand bits, try (4*root + 1).
    // A failed trial leaves the remainder below 4*root+1 <= 4093, so the
    // 12-bit remainder never loses information.
    assign w_rem_sh    = {r_rem, r_rad[19:18]};
    assign w_trial     = {2'b00, r_root, 2'b01};
    assign w_ge        = (w_rem_sh >= w_trial);
    assign w_rem_next  = w_ge ? 12'(w_rem_sh - w_trial) : w_rem_sh[11:0];
    assign w_root_next = {r_root[8:0], w_ge};

`ifdef L2_SQRT_ROUND_EN
    logic w_round;
    // Round to nearest: f > root^2 + root means the true root is >= root + 0.5
    assign w_round  = (w_rem_next > {2'b00, w_root_next}) && (w_root_next != 10'h3FF);
    assign w_result = w_root_next + {9'd0, w_round};
`else
    assign w_result = w_root_next;
`endif

    // FIFO storage; contents need no reset because the count gates every read
    always_ff @(posedge i_clk) begin
        if (w_push && !i_reset) begin
            r_mem[r_wr_ptr] <= {i_ovf_in, i_f};
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (i_valid_in && !w_push) begin
                r_drop <= 1'b1;
            end
        end
    end

    // Square-root engine: IDLE pops, ITER runs ten steps, DONE pulses the result
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_iter    <= 4'd0;
            r_rad     <= 20'd0;
            r_root    <= 10'd0;
            r_rem     <= 12'd0;
            r_ovf     <= 1'b0;
            r_r       <= 10'd0;
            r_valid   <= 1'b0;
            r_ovf_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_valid   <= 1'b0;
                    r_ovf_out <= 1'b0;
                    if (w_pop) begin
                        r_rad   <= w_head[19:0];
                        r_ovf   <= w_head[20];
                        r_root  <= 10'd0;
                        r_rem   <= 12'd0;
                        r_iter  <= 4'd9;
                        r_state <= ITER;
                    end
                end
                ITER: begin
                    r_rad  <= {r_rad[17:0], 2'b00};
                    r_root <= w_root_next;
                    r_rem  <= w_rem_next;
                    if (r_iter == 4'd0) begin
                        r_r       <= r_ovf ? 10'h3FF : w_result;
                        r_ovf_out <= r_ovf;
                        r_valid   <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_iter <= r_iter - 4'd1;
                    end
                end
                DONE: begin
                    r_valid   <= 1'b0;
                    r_ovf_out <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_valid   <= 1'b0;
                    r_ovf_out <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign o_r         = r_r;
    assign o_valid_out = r_valid;
    assign o_ovf_out   = r_ovf_out;
    assign o_drop      = r_drop;
    assign o_busy      = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_l2_sqrt.sv
// tb/tb_l2_sqrt.sv - directed self-checking bench for l2_sqrt
module tb_l2_sqrt;

    logic        clk;
    logic        reset;
    logic [19:0] f;
    logic        valid_in;
    logic        ovf_in;
    logic [9:0]  r;
    logic        valid_out;
    logic        ovf_out;
    logic        busy;
    logic        drop;

    int checks = 0;
    int errors = 0;

    l2_sqrt #(.FIFO_DEPTH(4)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_f         (f),
        .i_valid_in  (valid_in),
        .i_ovf_in    (ovf_in),
        .o_r         (r),
        .o_valid_out (valid_out),
        .o_ovf_out   (ovf_out),
        .o_busy      (busy),
        .o_drop      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance to the next cycle; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated sample: checks latency, single pulse, value, ovf and hold
    task automatic run_one(input string tag, input int fv, input bit ov,
                           input int exp_r, input int exp_ovf);
        int first = -1;
        int npulse = 0;
        int got_r = -1;
        int got_ovf = -1;
        int stray = 0;
        f        = 20'(fv);
        ovf_in   = ov;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        ovf_in   = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (valid_out) begin
                if (first < 0) first = k;
                npulse++;
                got_r   = int'(r);
                got_ovf = int'(ovf_out);
            end else if (ovf_out) begin
                stray++;
            end
            if (k == 13) begin
                chk({tag, "_hold_r"}, int'(r), exp_r);
                chk({tag, "_busy_after"}, int'(busy), 0);
            end
            step();
        end
        chk({tag, "_latency"}, first, 12);
        chk({tag, "_pulses"}, npulse, 1);
        chk({tag, "_r"}, got_r, exp_r);
        chk({tag, "_ovf"}, got_ovf, exp_ovf);
        chk({tag, "_stray_ovf"}, stray, 0);
    endtask

    int exp_157;
    int pulse_cyc [0:7];
    int pulse_r   [0:7];
    int np;
    int fvals [0:5];

    initial begin
`ifdef L2_SQRT_ROUND_EN
        exp_157 = 13;
`else
        exp_157 = 12;
`endif
        fvals[0] = 1; fvals[1] = 4; fvals[2] = 9;
        fvals[3] = 16; fvals[4] = 25; fvals[5] = 36;

        reset    = 1'b1;
        f        = 20'd0;
        valid_in = 1'b1;
        ovf_in   = 1'b1;
        step();
        step();
        chk("rst_r", int'(r), 0);
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_ovf", int'(ovf_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_drop", int'(drop), 0);
        valid_in = 1'b0;
        ovf_in   = 1'b0;
        reset    = 1'b0;
        step();

        run_one("f144", 144, 1'b0, 12, 0);
        run_one("f0", 0, 1'b0, 0, 0);
        run_one("fmax", 1048575, 1'b0, 1023, 0);
        run_one("f157", 157, 1'b0, exp_157, 0);
        run_one("f156", 156, 1'b0, 12, 0);
        run_one("ovf500", 500, 1'b1, 1023, 1);

        // Back-to-back burst of six into a depth-4 FIFO
        np = 0;
        for (int k = 0; k <= 70; k++) begin
            if (valid_out && np < 8) begin
                pulse_cyc[np] = k;
                pulse_r[np]   = int'(r);
                np++;
            end
            if (k == 5) chk("burst_drop_c5", int'(drop), 0);
            if (k == 6) chk("burst_drop_c6", int'(drop), 1);
            if (k < 6) begin
                f        = 20'(fvals[k]);
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            step();
        end
        chk("burst_count", np, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < np) begin
                chk($sformatf("burst_cyc%0d", i), pulse_cyc[i], 12 * (i + 1));
                chk($sformatf("burst_r%0d", i), pulse_r[i], i + 1);
            end
        end

        // Reset in cycle 6 of a computation aborts it and clears the drop flag
        f        = 20'd144;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) reset = 1'b1;
            step();
        end
        reset = 1'b0;
        chk("abort_valid", int'(valid_out), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_drop", int'(drop), 0);
        np = 0;
        for (int k = 8; k <= 25; k++) begin
            if (valid_out) np++;
            step();
        end
        chk("abort_no_result", np, 0);
        run_one("post_abort", 144, 1'b0, 12, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_sqrt.md
L2_SQRT -- requirements
Module: l2_sqrt

Interface
- REQ-001: Parameter FIFO_DEPTH, default 4, number of input sample entries buffered; SHALL be a power of two, 2 to 16.
- REQ-002: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-003: reset  input  1  synchronous, active-high reset.
- REQ-004: f  input  20  unsigned sum-of-squares sample from the upstream accumulator.
- REQ-005: valid_in  input  1  f and ovf_in are valid this cycle; there is no backpressure.
- REQ-006: ovf_in  input  1  upstream overflow flag qualifying f.
- REQ-007: r  output  10  unsigned integer square root of the sample.
- REQ-008: valid_out  output  1  one-cycle pulse marking r and ovf_out valid.
- REQ-009: ovf_out  output  1  result derived from an overflowed sample.
- REQ-010: busy  output  1  high when the engine is not IDLE or the FIFO is non-empty.
- REQ-011: drop  output  1  sticky flag: a sample was lost because the FIFO was full.

Function
- REQ-012: Each valid_in cycle SHALL write {ovf_in, f} into the FIFO at the closing edge, unless the FIFO is full after any same-edge pop.
- REQ-013: valid_in with the FIFO full and no same-edge pop SHALL discard the sample and set drop.
- REQ-014: Simultaneous write and pop on a full FIFO SHALL accept the write.
- REQ-015: A write into an empty FIFO SHALL NOT be popped on the same edge.
- REQ-016: The engine SHALL have states IDLE, ITER and DONE.
- REQ-017: IDLE with the FIFO non-empty SHALL pop the head, load the radicand, clear root and remainder, and go to ITER with iteration count 9.
- REQ-018: ITER SHALL run one restoring square-root step per cycle for 10 cycles, iteration counts 9 down to 0, processing 2 radicand bits per step; it SHALL then go to DONE.
- REQ-019: DONE SHALL assert valid_out for exactly one cycle, present r and ovf_out, and return to IDLE.
- REQ-020: Latency: a sample given in cycle 0 to an idle, empty block SHALL produce valid_out in cycle 12.
- REQ-021: Throughput SHALL be one result per 12 cycles.
- REQ-022: r SHALL equal floor(sqrt(f)) when the rounding feature is absent.
- REQ-023: A sample with ovf_in=1 SHALL yield r=10'h3FF and ovf_out=1 in its DONE cycle.
- REQ-024: ovf_out SHALL be 0 in every other cycle.
- REQ-025: r SHALL hold its last value while valid_out=0.
- REQ-026: Results SHALL emerge in arrival order.

Reset
- REQ-027: reset SHALL clear the FIFO, force IDLE, and zero r, valid_out, ovf_out, busy and drop at the next edge.
- REQ-028: reset SHALL take priority over any simultaneous valid_in.
- REQ-029: reset asserted mid-ITER or in DONE SHALL abort the computation, with no valid_out in the following cycle.

Configuration
- REQ-030: With macro L2_SQRT_ROUND_EN defined, r SHALL be rounded to nearest: floor root plus 1 when the final remainder exceeds the floor root, saturated at 1023.
- REQ-031: Rounding SHALL cost no extra latency.
- REQ-032: With L2_SQRT_ROUND_EN undefined, r SHALL be truncated (floor) and no rounding logic SHALL exist.

Verification
- REQ-033: Reset, then f=144, valid_in in cycle 0 -> valid_out=1 in cycle 12 only, r=12, ovf_out=0; all outputs 0 during reset.
- REQ-034: f=0 -> r=0; f=1048575 -> r=1023 (both builds).
- REQ-035: f=157 -> r=12 without L2_SQRT_ROUND_EN, r=13 with it; f=156 -> r=12 in both builds.
- REQ-036: f=500 with ovf_in=1 -> r=1023, ovf_out=1, valid_out in cycle 12.
- REQ-037: Six back-to-back valid_in in cycles 0-5, f=1,4,9,16,25,36 -> roots 1,2,3,4,5 at cycles 12,24,36,48,60; sixth sample dropped; drop=1 from cycle 6.
- REQ-038: Reset in cycle 6 of a computation -> valid_out stays 0, busy=0 and drop=0 next cycle; a new sample afterwards completes with the REQ-020 latency.
